// File: rtl/pc_unit.sv
// Fetch-stage program counter with relative/absolute jumps,
// a circular return-address stack and trap entry/return.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              STEP         = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [2:0]      pc_op,
    input  logic [XLEN-1:0] target_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] epc_out,
    output logic            in_trap,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic            double_fault
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] STEP_W  = XLEN'(STEP);
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_STEP = 3'd1,
        OP_JREL = 3'd2,
        OP_JABS = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_TRAP = 3'd6,
        OP_ERET = 3'd7
    } op_e;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_TRAP   = 1'b1
    } state_e;

    // Architectural state
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    state_e          r_state;
    logic            r_ovf;
    logic            r_unf;
    logic            r_df;

    // Return-address stack; r_wptr points at the next free slot,
    // which is also the oldest entry once the stack is full.
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;

    // Next-state wires
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_epc_nxt;
    state_e          w_state_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_nxt;
    logic            w_unf_nxt;
    logic            w_df_nxt;

    // Datapath helpers
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_rel;
    logic [PW-1:0]   w_ptr_dec;
    logic [PW-1:0]   w_ptr_inc;
    logic [XLEN-1:0] w_top;
    logic            w_empty;
    logic            w_full;
    op_e             w_op;

    assign w_op      = op_e'(pc_op);
    assign w_seq     = r_pc + STEP_W;
    assign w_rel     = r_pc + target_in;
    assign w_ptr_dec = r_wptr - PTR_ONE;
    assign w_ptr_inc = r_wptr + PTR_ONE;
    assign w_top     = r_ras[w_ptr_dec];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);

    always_comb begin
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        w_df_nxt    = 1'b0;
        unique case (w_op)
            OP_HOLD: begin
                w_pc_nxt = r_pc;
            end
            OP_STEP: begin
                w_pc_nxt = w_seq;
            end
            OP_JREL: begin
                w_pc_nxt = w_rel;
            end
            OP_JABS: begin
                w_pc_nxt = target_in;
            end
            OP_CALL: begin
                w_pc_nxt  = w_rel;
                w_push    = 1'b1;
                w_ovf_nxt = w_full;
            end
            OP_RET: begin
                if (w_empty) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_top;
                    w_pop    = 1'b1;
                end
            end
            OP_TRAP: begin
                w_pc_nxt    = TRAP_VECTOR;
                w_state_nxt = S_TRAP;
                if (r_state == S_TRAP) begin
                    w_df_nxt = 1'b1;
                end else begin
                    w_epc_nxt = r_pc;
                end
            end
            OP_ERET: begin
                if (r_state == S_TRAP) begin
                    w_pc_nxt    = r_epc;
                    w_state_nxt = S_NORMAL;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_state <= S_NORMAL;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_df    <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_state <= w_state_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            r_df    <= w_df_nxt;
        end
    end

    // A push into a full stack overwrites the oldest slot; count saturates.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_ras[r_wptr] <= w_seq;
            r_wptr        <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + CNT_ONE;
            end
        end else if (w_pop) begin
            r_wptr  <= w_ptr_dec;
            r_count <= r_count - CNT_ONE;
        end
    end

    assign pc_out        = r_pc;
    assign epc_out       = r_epc;
    assign in_trap       = (r_state == S_TRAP);
    assign misaligned    = (r_pc[1:0] != 2'b00);
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
    assign double_fault  = r_df;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised bench for pc_unit against a queue-based reference model,
// plus directed sequences with literal expectations.
module tb_pc_unit;

    localparam logic [2:0] HOLD = 3'd0, STEPO = 3'd1, JREL = 3'd2, JABS = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, TRAP = 3'd6, ERET = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [2:0]  pc_op = 3'd0;
    logic [31:0] target_in = '0;
    logic [31:0] pc_out, epc_out;
    logic        in_trap, misaligned, ras_empty, ras_full;
    logic        ras_overflow, ras_underflow, double_fault;

    pc_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .pc_op(pc_op), .target_in(target_in),
        .pc_out(pc_out), .epc_out(epc_out), .in_trap(in_trap),
        .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .double_fault(double_fault)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    // Reference model
    logic [31:0] m_pc, m_epc;
    bit          m_trap, m_ovf, m_unf, m_df;
    logic [31:0] m_ras[$];

    task automatic m_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_trap = 0;
        m_ovf = 0; m_unf = 0; m_df = 0;
        m_ras.delete();
    endtask

    task automatic m_apply(input logic [2:0] op, input logic [31:0] t);
        m_ovf = 0; m_unf = 0; m_df = 0;
        case (op)
            STEPO: m_pc = m_pc + 32'd4;
            JREL:  m_pc = m_pc + t;
            JABS:  m_pc = t;
            CALL: begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                m_ras.push_back(m_pc + 32'd4);
                m_pc = m_pc + t;
            end
            RET: begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else m_unf = 1;
            end
            TRAP: begin
                if (m_trap) m_df = 1;
                else begin m_epc = m_pc; m_trap = 1; end
                m_pc = 32'h100;
            end
            ERET: begin
                if (m_trap) begin m_pc = m_epc; m_trap = 0; end
            end
            default: ;
        endcase
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m_reset();
        else m_apply(pc_op, target_in);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("pc", pc_out, m_pc);
            chk("epc", epc_out, m_epc);
            chk("in_trap", 32'(in_trap), 32'(m_trap));
            chk("misaligned", 32'(misaligned), 32'(m_pc[1:0] != 2'b00));
            chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
            chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
            chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
            chk("double_fault", 32'(double_fault), 32'(m_df));
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] t);
        @(negedge Clk);
        pc_op = op;
        target_in = t;
        @(posedge Clk);
        #1;
        pc_op = HOLD;
    endtask

    task automatic mid_reset();
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_in_trap", 32'(in_trap), 32'h0);
        chk("rst_ras_empty", 32'(ras_empty), 32'h1);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] t;
        m_reset();
        #3;
        cmp_en = 1;
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_ras_empty", 32'(ras_empty), 32'h1);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        do_op(STEPO, 0); chk("step1", pc_out, 32'h4);
        do_op(STEPO, 0); chk("step2", pc_out, 32'h8);
        do_op(STEPO, 0); chk("step3", pc_out, 32'hC);
        chk("step_epc", epc_out, 32'h0);

        do_op(JABS, 32'h100);
        do_op(JREL, 32'hFFFF_FFF0); chk("jrel_neg", pc_out, 32'hF0);
        do_op(JABS, 32'hFFFF_FFFC); chk("jabs_top", pc_out, 32'hFFFF_FFFC);
        do_op(STEPO, 0); chk("step_wrap", pc_out, 32'h0);

        do_op(JABS, 32'h10);
        for (int i = 0; i < 5; i++) do_op(CALL, 32'h40);
        chk("call5_pc", pc_out, 32'h150);
        chk("call5_ovf", 32'(ras_overflow), 32'h1);
        chk("call5_full", 32'(ras_full), 32'h1);
        do_op(RET, 0); chk("ret1", pc_out, 32'h114);
        do_op(RET, 0); chk("ret2", pc_out, 32'hD4);
        do_op(RET, 0); chk("ret3", pc_out, 32'h94);
        do_op(RET, 0); chk("ret4", pc_out, 32'h54);
        do_op(RET, 0); chk("ret5_hold", pc_out, 32'h54);
        chk("ret5_unf", 32'(ras_underflow), 32'h1);
        chk("ret5_empty", 32'(ras_empty), 32'h1);

        do_op(JABS, 32'h200);
        do_op(TRAP, 0); chk("trap_pc", pc_out, 32'h100);
        chk("trap_epc", epc_out, 32'h200);
        chk("trap_in", 32'(in_trap), 32'h1);
        do_op(TRAP, 0); chk("trap2_epc", epc_out, 32'h200);
        chk("trap2_df", 32'(double_fault), 32'h1);
        do_op(ERET, 0); chk("eret_pc", pc_out, 32'h200);
        chk("eret_in", 32'(in_trap), 32'h0);
        do_op(ERET, 0); chk("eret2_pc", pc_out, 32'h200);

        do_op(JABS, 32'h6); chk("mis_pc", pc_out, 32'h6);
        chk("mis1", 32'(misaligned), 32'h1);
        do_op(STEPO, 0); chk("mis_step", pc_out, 32'hA);
        chk("mis2", 32'(misaligned), 32'h1);
        do_op(JABS, 32'h8); chk("mis3", 32'(misaligned), 32'h0);

        do_op(CALL, 32'h20);
        do_op(CALL, 32'h20);
        do_op(TRAP, 0);
        mid_reset();
        do_op(STEPO, 0); chk("post_rst_step", pc_out, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) t = $urandom;
            else t = (32'($urandom_range(0, 64)) << 2) - 32'd128;
            if ($urandom_range(0, 299) == 0) mid_reset();
            else do_op(op, t);
        end

        @(negedge Clk);
        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
